// File: rtl/iob_rr_merge_pkg.sv
// Shared IOb bus constants and field offsets for the round-robin merge and its arbiter.
// Flattened slices follow the interconnect layout: request {valid, address, wdata, wstrb}, response {rdata, ready}.
package iob_rr_merge_pkg;

    typedef enum logic {
        IDLE = 1'b0,
        BUSY = 1'b1
    } state_t;

    function automatic int req_w(input int addr_w, input int data_w);
        return 1 + addr_w + data_w + data_w / 8;
    endfunction

    function automatic int resp_w(input int data_w);
        return data_w + 1;
    endfunction

    // Bit offsets of the fields of slice i inside a flattened request bus.
    function automatic int wstrb(input int i, input int addr_w, input int data_w);
        return i * req_w(addr_w, data_w);
    endfunction

    function automatic int wdata(input int i, input int addr_w, input int data_w);
        return wstrb(i, addr_w, data_w) + data_w / 8;
    endfunction

    function automatic int address(input int i, input int addr_w, input int data_w);
        return wdata(i, addr_w, data_w) + data_w;
    endfunction

    function automatic int valid(input int i, input int addr_w, input int data_w);
        return address(i, addr_w, data_w) + addr_w;
    endfunction

    // Bit offsets of the fields of slice i inside a flattened response bus.
    function automatic int ready(input int i, input int data_w);
        return i * resp_w(data_w);
    endfunction

    function automatic int rdata(input int i, input int data_w);
        return ready(i, data_w) + 1;
    endfunction

endpackage

// File: rtl/iob_rr_arbiter.sv
// Combinational round-robin priority rotator: picks the first requester after 'last', wrapping modulo N.
module iob_rr_arbiter
    import iob_rr_merge_pkg::*;
#(
    parameter int N = 2,
    localparam int IDX_W = $clog2(N)
) (
    input  logic [N-1:0]     req,
    input  logic [IDX_W-1:0] last,
    output logic [IDX_W-1:0] sel,
    output logic             any
);

    logic [IDX_W-1:0] idx;

    // Scan from farthest to nearest so the nearest requester after 'last' is written last and wins.
    always_comb begin
        sel = '0;
        idx = '0;
        any = |req;
        for (int k = N; k >= 1; k--) begin
            idx = IDX_W'((int'(last) + k) % N);
            if (req[idx]) begin
                sel = idx;
            end
        end
    end

endmodule

// File: rtl/iob_rr_merge.sv
// N-master to 1-slave IOb merge with round-robin arbitration and one outstanding transaction.
// Grant is held from acceptance until the slave's ready pulse, which is forwarded in the same cycle.
module iob_rr_merge
    import iob_rr_merge_pkg::*;
#(
    parameter int N_MASTERS = 2,
    parameter int ADDR_W = 32,
    parameter int DATA_W = 32,
    localparam int REQ_W = req_w(ADDR_W, DATA_W),
    localparam int RESP_W = resp_w(DATA_W),
    localparam int IDX_W = $clog2(N_MASTERS)
) (
    input  logic                          clk,
    input  logic                          rst,
    input  logic [N_MASTERS*REQ_W-1:0]    m_req,
    output logic [N_MASTERS*RESP_W-1:0]   m_resp,
    output logic [REQ_W-1:0]              s_req,
    input  logic [RESP_W-1:0]             s_resp,
    output logic                          busy
);

    state_t           state, state_next;
    logic [IDX_W-1:0] grant, grant_next;
    logic [IDX_W-1:0] last, last_next;
    logic [N_MASTERS-1:0] m_valid;
    logic [IDX_W-1:0] sel;
    logic             any;

    for (genvar i = 0; i < N_MASTERS; i++) begin : g_valid
        assign m_valid[i] = m_req[(i + 1) * REQ_W - 1];
    end

    iob_rr_arbiter #(
        .N(N_MASTERS)
    ) u_arbiter (
        .req (m_valid),
        .last(last),
        .sel (sel),
        .any (any)
    );

    always_ff @(posedge clk) begin
        if (!rst) begin
            state <= IDLE;
            grant <= '0;
            last  <= IDX_W'(N_MASTERS - 1);
        end else begin
            state <= state_next;
            grant <= grant_next;
            last  <= last_next;
        end
    end

    // Outputs stay all-zero in IDLE, so a slave ready arriving there is simply not forwarded.
    always_comb begin
        state_next = state;
        grant_next = grant;
        last_next  = last;
        s_req      = '0;
        m_resp     = '0;
        busy       = 1'b0;
        case (state)
            IDLE: begin
                if (any) begin
                    grant_next = sel;
                    state_next = BUSY;
                end
            end
            BUSY: begin
                busy = 1'b1;
                for (int i = 0; i < N_MASTERS; i++) begin
                    if (grant == IDX_W'(i)) begin
                        s_req = m_req[i*REQ_W +: REQ_W];
                    end
                end
                // Valid is forced so a master that drops valid early still completes its transfer.
                s_req[REQ_W-1] = 1'b1;
                if (s_resp[0]) begin
                    for (int i = 0; i < N_MASTERS; i++) begin
                        if (grant == IDX_W'(i)) begin
                            m_resp[i*RESP_W +: RESP_W] = {s_resp[RESP_W-1:1], 1'b1};
                        end
                    end
                    last_next  = grant;
                    state_next = IDLE;
                end
            end
            default: state_next = IDLE;
        endcase
    end

endmodule

// File: doc/iob_rr_merge.md
Name: iob_rr_merge

Overview:
- N-master to 1-slave merge on the native IOb bus, round-robin arbitrated.
- Sits upstream of ext_mem and int_mem data ports. Lets the CPU data bus and the Versat accelerator's memory master share one memory slave.
- One outstanding transaction at a time.
- Grant is held from acceptance until the slave's ready pulse.

Parameters:
- N_MASTERS, 2, number of IOb masters (2..8).
- ADDR_W, 32, IOb address width.
- DATA_W, 32, IOb data width; wstrb width is DATA_W/8.

Ports:
- clk  in  1  system clock.
- rst  in  1  synchronous reset, active-low (asserted when 0).
- m_req  in  N_MASTERS*REQ_W  master requests.
  - REQ_W = 1+ADDR_W+DATA_W+DATA_W/8.
  - Slice i = {valid, address, wdata, wstrb}, valid at MSB.
- m_resp  out  N_MASTERS*RESP_W  master responses.
  - RESP_W = DATA_W+1.
  - Slice i = {rdata, ready}, ready at LSB.
- s_req  out  REQ_W  request to slave.
- s_resp  in  RESP_W  response from slave.
- busy  out  1  high while a transaction is granted and not yet completed.

Behaviour:
- IOb rules:
  - A master holds valid, address, wdata and wstrb stable until the cycle its ready is 1.
  - ready is a single-cycle pulse carrying rdata.
  - wstrb=0 means read; nonzero means write.
- Registered state:
  - state in {IDLE, BUSY}.
  - grant index, $clog2(N_MASTERS) bits.
  - last index, same width.
- Reset (rst==0 at a clk edge):
  - state=IDLE, grant=0, last=N_MASTERS-1.
  - All outputs 0 the following cycle: s_req valid=0, busy=0, every m_resp ready=0.
  - Reset mid-BUSY abandons the transaction; no ready is ever delivered for it.
- IDLE:
  - If any master valid is 1, select the first valid master scanning (last+1), (last+2), ... mod N_MASTERS.
  - Load grant with the selected index; next state BUSY.
  - No valid: remain IDLE.
- BUSY:
  - s_req = m_req slice[grant], combinationally muxed, with valid forced to 1.
  - busy=1.
  - On s_resp.ready==1:
    - m_resp[grant] = {s_resp.rdata, 1} in that same cycle (zero added response latency).
    - last <= grant; next state IDLE.
- IDLE outputs:
  - s_req is all zeros (valid=0, address/wdata/wstrb=0).
  - All m_resp ready=0.
- Non-granted masters:
  - ready is always 0.
  - rdata is driven 0 for non-granted masters in all states.
- Latency: request visible on the slave 1 cycle after the master's valid rises (IDLE->BUSY edge). Minimum turnaround is 2 cycles per transaction with a 0-wait slave responding in the first BUSY cycle.
- Spurious s_resp.ready in IDLE is ignored: no m_resp ready, no state change.
- A master dropping valid while granted violates the protocol. The grant is still held until s_ready and the ready pulse is still delivered to that index.
- Simultaneous requests: exactly one grant. The losing masters keep valid asserted and are served in round-robin order, so no starvation. Worst-case wait is N_MASTERS-1 transactions.
- Wrap-around: the scan index wraps modulo N_MASTERS. For non-power-of-2 N, indices >= N_MASTERS are never produced.

Decomposition:
- Shared package/header constants: REQ_W and RESP_W expressions; field offset macros valid(i), address(i,W), wdata(i), wstrb(i), rdata(i), ready(i), consistent with the existing interconnect header.
- One sub-module: iob_rr_arbiter.
  - Purely combinational priority rotator.
  - Inputs: req vector and last.
  - Outputs: sel index and any.
  - Reusable by other merges.
- State register, mux and response demux live in iob_rr_merge.

Test Plan:
- Single read, N=2: M1 read addr 0x100; slave returns rdata 0xDEADBEEF with ready on first BUSY cycle -> s_req valid 1 cycle after M1 valid; M1 ready=1 with rdata 0xDEADBEEF; M0 ready stays 0; busy falls next cycle.
- Simultaneous requests after reset: M0 write 0x10 wdata 0x11 wstrb 0xF and M1 read 0x20 -> M0 served first (last=N-1), then M1; slave sees 0x10 then 0x20 and each address exactly once.
- Fairness: both masters request continuously for 6 transactions -> grant sequence 0,1,0,1,0,1.
- Wrap, N=3: M2 served last, then M0 and M2 request -> M0 granted.
- Spurious ready in IDLE (s_resp ready=1, rdata=0x55) -> no master ready, state stays IDLE.
- Reset mid-BUSY with slave stalled: rst=0 for 1 cycle -> next cycle s_req valid=0, busy=0; a later slave ready is ignored; next request from M1 is granted normally.
